// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline latch, write-back data select, 32x32 register
// file with bypass, and a retired-instruction counter.
//
// Ports
//   clk               single clock, rising-edge
//   clrn              synchronous active-low reset
//   stall             hold the MEM/WB latch and suppress commit
//   mvalid/mwreg/mm2reg/mrn/malu/mmo   MEM-stage instruction fields
//   rna, rnb          register-file read addresses
//   qa, qb            register-file read data (with write-back bypass)
//   wvalid/wwreg/wm2reg/wrn            latched WB-stage control
//   wdi               selected write-back data
//   retired           count of committed instructions (wraps)
module wb_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             stall,
  input  logic             mvalid,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  input  logic [31:0]      malu,
  input  logic [31:0]      mmo,
  input  logic [4:0]       rna,
  input  logic [4:0]       rnb,
  output logic [31:0]      qa,
  output logic [31:0]      qb,
  output logic             wvalid,
  output logic             wwreg,
  output logic             wm2reg,
  output logic [4:0]       wrn,
  output logic [31:0]      wdi,
  output logic [CNT_W-1:0] retired
);

  logic             r_wvalid;
  logic             r_wwreg;
  logic             r_wm2reg;
  logic [4:0]       r_wrn;
  logic [31:0]      r_malu;
  logic [31:0]      r_mmo;
  logic [CNT_W-1:0] r_retired;
  logic [31:0]      r_rf [32];

  logic             w_commit;
  logic             w_we;
  logic [31:0]      w_wdi;

  assign w_commit = r_wvalid & ~stall;
  // r0 is hard-wired to zero, so a write to it is dropped here rather than
  // masked on the read side only.
  assign w_we     = w_commit & r_wwreg & (r_wrn != 5'd0);
  assign w_wdi    = r_wm2reg ? r_mmo : r_malu;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_wvalid  <= 1'b0;
      r_wwreg   <= 1'b0;
      r_wm2reg  <= 1'b0;
      r_wrn     <= 5'd0;
      r_malu    <= 32'd0;
      r_mmo     <= 32'd0;
      r_retired <= '0;
    end else begin
      if (!stall) begin
        r_wvalid <= mvalid;
        r_wwreg  <= mwreg;
        r_wm2reg <= mm2reg;
        r_wrn    <= mrn;
        r_malu   <= malu;
        r_mmo    <= mmo;
      end
      // Commits with no register write (wwreg=0 or wrn=0) still retire.
      if (w_commit) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= 32'd0;
      end
    end else if (w_we) begin
      r_rf[r_wrn] <= w_wdi;
    end
  end

  // Same-cycle bypass: a reader sees the value that lands at the next edge.
  always_comb begin
    qa = r_rf[rna];
    if (rna == 5'd0) begin
      qa = 32'd0;
    end else if (w_we && (rna == r_wrn)) begin
      qa = w_wdi;
    end
  end

  always_comb begin
    qb = r_rf[rnb];
    if (rnb == 5'd0) begin
      qb = 32'd0;
    end else if (w_we && (rnb == r_wrn)) begin
      qb = w_wdi;
    end
  end

  assign wvalid  = r_wvalid;
  assign wwreg   = r_wwreg;
  assign wm2reg  = r_wm2reg;
  assign wrn     = r_wrn;
  assign wdi     = w_wdi;
  assign retired = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage. A 16-bit-counter
// instance carries all checks; a 4-bit-counter instance shares the same
// stimulus so the counter wrap can be observed.
module tb_wb_stage;

  logic        clk;
  logic        clrn;
  logic        stall;
  logic        mvalid;
  logic        mwreg;
  logic        mm2reg;
  logic [4:0]  mrn;
  logic [31:0] malu;
  logic [31:0] mmo;
  logic [4:0]  rna;
  logic [4:0]  rnb;

  logic [31:0] qa, qb, wdi;
  logic        wvalid, wwreg, wm2reg;
  logic [4:0]  wrn;
  logic [15:0] retired;

  logic [31:0] qa4, qb4, wdi4;
  logic        wvalid4, wwreg4, wm2reg4;
  logic [4:0]  wrn4;
  logic [3:0]  retired4;

  int n_checks;
  int n_fail;

  wb_stage #(.CNT_W(16)) dut (
    .clk(clk), .clrn(clrn), .stall(stall), .mvalid(mvalid), .mwreg(mwreg),
    .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo), .rna(rna), .rnb(rnb),
    .qa(qa), .qb(qb), .wvalid(wvalid), .wwreg(wwreg), .wm2reg(wm2reg),
    .wrn(wrn), .wdi(wdi), .retired(retired)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .clrn(clrn), .stall(stall), .mvalid(mvalid), .mwreg(mwreg),
    .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo), .rna(rna), .rnb(rnb),
    .qa(qa4), .qb(qb4), .wvalid(wvalid4), .wwreg(wwreg4), .wm2reg(wm2reg4),
    .wrn(wrn4), .wdi(wdi4), .retired(retired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mvalid;
    logic        mwreg;
    logic        mm2reg;
    logic [4:0]  mrn;
    logic [31:0] malu;
    logic [31:0] mmo;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic        e_wvalid;
    logic [4:0]  e_wrn;
    logic [31:0] e_wdi;
    logic [31:0] e_qa;
    logic [31:0] e_qb;
    logic [15:0] e_ret;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic m2r,
                       input logic [4:0] rn, input logic [31:0] alu,
                       input logic [31:0] mo);
    mvalid = v;
    mwreg  = w;
    mm2reg = m2r;
    mrn    = rn;
    malu   = alu;
    mmo    = mo;
  endtask

  task automatic do_reset();
    clrn  = 1'b0;
    stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    step();
    clrn = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clrn  = 1'b1;
    stall = 1'b0;
    rna   = 5'd0;
    rnb   = 5'd0;
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'hCAFE_F00D, 32'h1);

    // Directed sequence after reset; expectations taken one ns after each edge.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd5,  32'h0000_1234, 32'h0,  5'd5,  5'd0,
                1'b1, 5'd5,  32'h0000_1234, 32'h0000_1234, 32'h0,         16'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd3,  32'h0000_DEAD, 32'h8,  5'd5,  5'd3,
                1'b1, 5'd3,  32'h0000_0008, 32'h0000_1234, 32'h0000_0008, 16'd1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd0,  32'hFFFF_FFFF, 32'h0,  5'd3,  5'd0,
                1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0000_0008, 32'h0,         16'd2};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 5'd6,  32'h0000_0077, 32'h0,  5'd0,  5'd5,
                1'b0, 5'd6,  32'h0000_0077, 32'h0,         32'h0000_1234, 16'd3};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd5,  32'h0000_AAAA, 32'h0,  5'd5,  5'd3,
                1'b1, 5'd5,  32'h0000_AAAA, 32'h0000_1234, 32'h0000_0008, 16'd3};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_0111, 32'h0,  5'd10, 5'd5,
                1'b1, 5'd10, 32'h0000_0111, 32'h0000_0111, 32'h0000_1234, 16'd4};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_0222, 32'h0,  5'd10, 5'd0,
                1'b1, 5'd10, 32'h0000_0222, 32'h0000_0222, 32'h0,         16'd5};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,  5'd10, 5'd10,
                1'b0, 5'd0,  32'h0,         32'h0000_0222, 32'h0000_0222, 16'd6};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         32'h0,  5'd3,  5'd5,
                1'b0, 5'd0,  32'h0,         32'h0000_0008, 32'h0000_1234, 16'd6};

    // Reset state
    do_reset();
    chk("rst_wvalid",  {31'd0, wvalid},  32'd0);
    chk("rst_wwreg",   {31'd0, wwreg},   32'd0);
    chk("rst_wm2reg",  {31'd0, wm2reg},  32'd0);
    chk("rst_wrn",     {27'd0, wrn},     32'd0);
    chk("rst_wdi",     wdi,              32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      rna = 5'(a);
      rnb = 5'(31 - a);
      #1;
      chk("rst_qa", qa, 32'd0);
      chk("rst_qb", qb, 32'd0);
    end

    // Table-driven main function
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].mvalid, vecs[i].mwreg, vecs[i].mm2reg, vecs[i].mrn,
            vecs[i].malu, vecs[i].mmo);
      rna = vecs[i].rna;
      rnb = vecs[i].rnb;
      step();
      chk("tbl_wvalid",  {31'd0, wvalid},  {31'd0, vecs[i].e_wvalid});
      chk("tbl_wrn",     {27'd0, wrn},     {27'd0, vecs[i].e_wrn});
      chk("tbl_wdi",     wdi,              vecs[i].e_wdi);
      chk("tbl_qa",      qa,               vecs[i].e_qa);
      chk("tbl_qb",      qb,               vecs[i].e_qb);
      chk("tbl_retired", {16'd0, retired}, {16'd0, vecs[i].e_ret});
    end

    // Stall: latch r7<-0x55, hold 3 cycles, then exactly one commit
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h55, 32'h0);
    rna = 5'd7;
    rnb = 5'd0;
    step();
    chk("stl_latch_wrn", {27'd0, wrn}, 32'd7);
    stall = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stl_hold_wrn",  {27'd0, wrn},     32'd7);
      chk("stl_hold_wdi",  wdi,              32'h55);
      chk("stl_hold_qa",   qa,               32'd0);
      chk("stl_hold_ret",  {16'd0, retired}, 32'd6);
    end
    stall = 1'b0;
    #1;
    chk("stl_release_bypass", qa, 32'h55);
    step();
    chk("stl_commit_ret", {16'd0, retired}, 32'd7);
    chk("stl_commit_qa",  qa,               32'h55);
    step();
    chk("stl_once_ret",   {16'd0, retired}, 32'd7);

    // Reset with a writing instruction in WB: discarded, no write
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0);
    rna = 5'd9;
    rnb = 5'd10;
    step();
    chk("rmid_latched_wvalid", {31'd0, wvalid}, 32'd1);
    clrn  = 1'b0;
    stall = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    clrn  = 1'b1;
    stall = 1'b0;
    #1;
    chk("rmid_wvalid",  {31'd0, wvalid},  32'd0);
    chk("rmid_retired", {16'd0, retired}, 32'd0);
    chk("rmid_qa_r9",   qa,               32'd0);
    chk("rmid_qb_r10",  qb,               32'd0);
    step();
    chk("rmid_qa_r9_later", qa,               32'd0);
    chk("rmid_ret_later",   {16'd0, retired}, 32'd0);

    // Counter wrap: 17 commits; 4-bit counter lands on 1
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 5'd1, 32'h0, 32'h0);
    for (int c = 0; c < 17; c++) begin
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk("wrap_ret4",  {28'd0, retired4}, 32'd1);
    chk("wrap_ret16", {16'd0, retired},  32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clrn  input  1  reset, synchronous and active-low.
REQ-004 stall  input  1  hold the MEM/WB latch; suppress commit.
REQ-005 mvalid  input  1  MEM-stage slot holds a real instruction.
REQ-006 mwreg  input  1  MEM-stage instruction writes a register.
REQ-007 mm2reg  input  1  write data comes from memory (1) or the ALU (0).
REQ-008 mrn  input  5  MEM-stage destination register number.
REQ-009 malu  input  32  MEM-stage ALU result.
REQ-010 mmo  input  32  data-memory read data (MEM stage dataout).
REQ-011 rna, rnb  input  5 each  register-file read addresses.
REQ-012 qa, qb  output  32 each  register-file read data, with bypass.
REQ-013 wvalid, wwreg, wm2reg  output  1 each  latched WB-stage control.
REQ-014 wrn  output  5  latched WB-stage destination.
REQ-015 wdi  output  32  selected write-back data.
REQ-016 retired  output  CNT_W  count of committed instructions.

Function
REQ-017 MEM/WB latch SHALL capture {mvalid, mwreg, mm2reg, mrn, malu, mmo} on each rising edge with clrn=1 and stall=0.
REQ-018 With stall=1, the latch SHALL hold its contents unchanged.
REQ-019 wdi SHALL be combinational: latched mmo if wm2reg=1, else latched malu.
REQ-020 Commit condition: wvalid=1 and stall=0.
REQ-021 Register write SHALL occur at the rising edge ending a commit cycle when wwreg=1 and wrn!=0: rf[wrn] <= wdi.
REQ-022 Register 0 SHALL never be written; qa/qb SHALL read 0 for address 0 regardless of bypass.
REQ-023 The register file SHALL hold 32 entries of 32 bits with two combinational read ports.
REQ-024 Bypass: if a write is pending this cycle (REQ-021 condition true) and rna==wrn, qa SHALL equal wdi; otherwise rf[rna]. The same rule applies to qb/rnb.
REQ-025 No bypass SHALL occur while stall=1, wvalid=0, or wwreg=0.
REQ-026 retired SHALL increment by 1 on each commit, including commits with wwreg=0 or wrn=0, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-027 Latency: inputs sampled at edge N are visible on w* outputs after edge N; the register write lands at edge N+1 if not stalled.
REQ-028 A held (stalled) instruction SHALL commit exactly once, in the first cycle with stall=0.
REQ-029 Back-to-back writes to the same register SHALL each commit in order; the later value SHALL persist.

Reset
REQ-030 At a rising edge with clrn=0: wvalid, wwreg, wm2reg := 0; wrn := 0; latched malu/mmo := 0; all 32 registers := 0; retired := 0.
REQ-031 Reset SHALL take priority over stall and over any pending commit; an instruction in the WB stage at reset SHALL be discarded without writing.
REQ-032 After reset, wdi=0 and qa=qb=0 for every address.

Verification
REQ-033 ALU write: mvalid=1, mwreg=1, mm2reg=0, mrn=5, malu=0x1234 -> after edge 1, wdi=0x1234; with rna=5, qa=0x1234 via bypass; after edge 2, with no pending write, qa=0x1234 from rf; retired=1.
REQ-034 Load write: mm2reg=1, mrn=3, mmo=0x00000008, malu=0xDEAD -> wdi=0x8; rf[3]=0x8 after commit.
REQ-035 Write to r0: mrn=0, malu=0xFFFFFFFF -> rnb=0 gives qb=0 on every cycle; retired still increments.
REQ-036 Stall: instruction latched (mrn=7, malu=0x55), then stall=1 for 3 cycles -> rf[7] is not written and retired is unchanged during the stall; qa (rna=7) shows the old value; after stall falls, exactly one commit occurs and retired increments by 1.
REQ-037 Reset mid-operation: instruction latched with mwreg=1, mrn=9, then clrn=0 for one edge -> rf[9]=0, wvalid=0, retired=0.
REQ-038 Counter wrap, CNT_W=4: 17 consecutive commits -> retired=1.
